// File: rtl/addsub_flags_pipe.sv
// rtl/addsub_flags_pipe.sv - registered add/sub result stage with comparison flags, 2-entry skid buffer and overflow status
module addsub_flags_pipe #(
   parameter int WORD_WIDTH  = 0,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_WIDTH-1:0]  in_sum,
   input  logic                   in_carry_out,
   input  logic                   in_overflow,
   input  logic                   in_A_negative,
   input  logic                   in_B_negative,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_WIDTH-1:0]  out_sum,
   output logic                   out_zero,
   output logic                   out_negative,
   output logic                   out_carry,
   output logic                   out_overflow,
   output logic                   out_lt_signed,
   output logic                   out_lt_unsigned,
   input  logic                   sticky_clear,
   output logic                   sticky_overflow,
   output logic [COUNT_WIDTH-1:0] overflow_count
);

   // payload = {sum, carry, overflow, zero, negative, lt_signed, lt_unsigned}
   localparam int PAYLOAD_WIDTH = WORD_WIDTH + 6;

   logic [PAYLOAD_WIDTH-1:0] in_payload;
   logic [PAYLOAD_WIDTH-1:0] out_payload;
   logic [PAYLOAD_WIDTH-1:0] skid_payload;
   logic [PAYLOAD_WIDTH-1:0] out_payload_next;
   logic [PAYLOAD_WIDTH-1:0] skid_payload_next;
   logic                     skid_valid;
   logic                     out_valid_next;
   logic                     skid_valid_next;
   logic                     in_xfer;
   logic                     out_xfer;
   logic                     in_zero;
   logic                     in_negative;
   logic                     is_sub;
   logic                     overflow_delivered;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Predicates travel with the data so they always match out_sum.
   assign in_zero     = (in_sum == '0);
   assign in_negative = in_sum[WORD_WIDTH-1];
   assign is_sub      = ~in_A_negative & in_B_negative;
   assign in_payload  = {in_sum, in_carry_out, in_overflow, in_zero, in_negative,
                         in_negative ^ in_overflow, is_sub & ~in_carry_out};

   assign {out_sum, out_carry, out_overflow, out_zero, out_negative,
           out_lt_signed, out_lt_unsigned} = out_payload;

   always_comb begin
      out_valid_next    = out_valid;
      skid_valid_next   = skid_valid;
      out_payload_next  = out_payload;
      skid_payload_next = skid_payload;
      if (out_xfer && skid_valid) begin
         out_payload_next = skid_payload;
         skid_valid_next  = in_xfer;
         if (in_xfer) begin
            skid_payload_next = in_payload;
         end
      end else if (!out_valid || out_xfer) begin
         out_valid_next = in_xfer;
         if (in_xfer) begin
            out_payload_next = in_payload;
         end
      end else if (in_xfer) begin
         skid_valid_next   = 1'b1;
         skid_payload_next = in_payload;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         out_valid    <= 1'b0;
         skid_valid   <= 1'b0;
         in_ready     <= 1'b1;
         out_payload  <= '0;
         skid_payload <= '0;
      end else begin
         out_valid    <= out_valid_next;
         skid_valid   <= skid_valid_next;
         in_ready     <= ~skid_valid_next;
         out_payload  <= out_payload_next;
         skid_payload <= skid_payload_next;
      end
   end

   // Status counts results actually handed downstream, not ones accepted.
   assign overflow_delivered = out_xfer & out_overflow;

   always_ff @(posedge clock) begin
      if (clear) begin
         sticky_overflow <= 1'b0;
         overflow_count  <= '0;
      end else begin
         if (overflow_delivered) begin
            sticky_overflow <= 1'b1;
         end else if (sticky_clear) begin
            sticky_overflow <= 1'b0;
         end
         if (overflow_delivered && (overflow_count != {COUNT_WIDTH{1'b1}})) begin
            overflow_count <= overflow_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_addsub_flags_pipe.sv
// tb/tb_addsub_flags_pipe.sv - scoreboard bench for addsub_flags_pipe
module tb_addsub_flags_pipe;

   logic       clock = 1'b0;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_sum;
   logic       in_carry_out;
   logic       in_overflow;
   logic       in_A_negative;
   logic       in_B_negative;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_zero;
   logic       out_negative;
   logic       out_carry;
   logic       out_overflow;
   logic       out_lt_signed;
   logic       out_lt_unsigned;
   logic       sticky_clear;
   logic       sticky_overflow;
   logic [7:0] overflow_count;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [13:0] sb[$];

   addsub_flags_pipe #(.WORD_WIDTH(8), .COUNT_WIDTH(8)) dut (
      .clock(clock), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .in_carry_out(in_carry_out), .in_overflow(in_overflow),
      .in_A_negative(in_A_negative), .in_B_negative(in_B_negative),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_zero(out_zero), .out_negative(out_negative), .out_carry(out_carry),
      .out_overflow(out_overflow), .out_lt_signed(out_lt_signed),
      .out_lt_unsigned(out_lt_unsigned), .sticky_clear(sticky_clear),
      .sticky_overflow(sticky_overflow), .overflow_count(overflow_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [13:0] pack(input logic [7:0] s, input logic c, o, z, n, lts, ltu);
      return {s, c, o, z, n, lts, ltu};
   endfunction

   // Monitor: one pop per output transfer, which happens at the next rising edge.
   always @(negedge clock) begin
      if (clear === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_delivery", {18'd0, out_sum, out_carry, out_overflow, out_zero,
                  out_negative, out_lt_signed, out_lt_unsigned}, 32'hFFFF_FFFF);
         end else begin
            check("delivery", {18'd0, out_sum, out_carry, out_overflow, out_zero,
                  out_negative, out_lt_signed, out_lt_unsigned}, {18'd0, sb.pop_front()});
         end
      end
   end

   // Offer one result and return at posedge+1 after it is accepted.
   task automatic send(input logic [7:0] s, input logic c, o, an, bn, z, n, lts, ltu);
      bit done = 0;
      in_valid = 1'b1; in_sum = s; in_carry_out = c; in_overflow = o;
      in_A_negative = an; in_B_negative = bn;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clock);
         if (in_ready === 1'b1) begin
            @(posedge clock);
            sb.push_back(pack(s, c, o, z, n, lts, ltu));
            done = 1;
         end
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clear = 1'b1; in_valid = 1'b1; in_sum = 8'h55; in_carry_out = 1'b1; in_overflow = 1'b1;
      in_A_negative = 1'b0; in_B_negative = 1'b1; out_ready = 1'b1; sticky_clear = 1'b0;
      repeat (2) @(posedge clock);
      #1 clear = 1'b0; in_valid = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sticky", sticky_overflow, 0);
      check("rst_count", overflow_count, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_zero", out_zero, 0);
      idle(1);
      check("rst_no_capture", out_valid, 0);

      // 5-5, 3-5, 3+(-5)-style add with same fields, 0x7F+0x01
      send(8'h00, 1, 0, 0, 1, 1, 0, 0, 0);
      check("latency_valid", out_valid, 1);
      check("latency_sum", out_sum, 8'h00);
      send(8'hFE, 0, 0, 0, 1, 0, 1, 1, 1);
      send(8'hFE, 0, 0, 0, 0, 0, 1, 1, 0);
      send(8'h80, 0, 1, 0, 0, 0, 1, 0, 0);
      idle(2);
      check("sticky_after_ovf", sticky_overflow, 1);
      check("count_after_ovf", overflow_count, 1);

      // Backpressure: 1 in output reg, 2 in skid, 3 held upstream
      out_ready = 1'b0;
      send(8'h01, 0, 0, 0, 0, 0, 0, 0, 0);
      check("bp_ready_after_1", in_ready, 1);
      send(8'h02, 0, 0, 0, 0, 0, 0, 0, 0);
      check("bp_ready_low", in_ready, 0);
      in_valid = 1'b1; in_sum = 8'h03; in_carry_out = 0; in_overflow = 0;
      in_A_negative = 0; in_B_negative = 0;
      idle(3);
      check("bp_ready_held", in_ready, 0);
      check("bp_out_sum", out_sum, 8'h01);
      check("bp_out_valid", out_valid, 1);
      check("bp_sb_depth", sb.size(), 2);
      out_ready = 1'b1;
      send(8'h03, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      check("bp_drained", sb.size(), 0);
      check("bp_out_valid_end", out_valid, 0);

      // Overflow counter: 1 so far, then 260 more -> saturates at 255
      for (int i = 0; i < 100; i++) send(8'h80, 0, 1, 0, 0, 0, 1, 0, 0);
      idle(3);
      check("count_101", overflow_count, 101);
      for (int i = 0; i < 160; i++) send(8'h80, 0, 1, 0, 0, 0, 1, 0, 0);
      idle(3);
      check("count_sat", overflow_count, 255);
      sticky_clear = 1'b1;
      idle(1);
      sticky_clear = 1'b0;
      check("sticky_cleared", sticky_overflow, 0);
      check("count_kept", overflow_count, 255);
      send(8'h80, 0, 1, 0, 0, 0, 1, 0, 0);
      sticky_clear = 1'b1;
      idle(1);
      sticky_clear = 1'b0;
      check("sticky_set_wins", sticky_overflow, 1);
      check("count_no_wrap", overflow_count, 255);

      // Mid-stream clear discards both buffered entries
      out_ready = 1'b0;
      send(8'h81, 0, 1, 0, 0, 0, 1, 0, 0);
      send(8'h82, 0, 1, 0, 0, 0, 1, 0, 0);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      sb.delete();
      check("clr_out_valid", out_valid, 0);
      check("clr_in_ready", in_ready, 1);
      check("clr_sticky", sticky_overflow, 0);
      check("clr_count", overflow_count, 0);
      out_ready = 1'b1;
      idle(3);
      check("clr_out_valid_late", out_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
